// File: rtl/dsp_seq_nmul_pkg.sv
// Shared definitions for the sequential N-operand signed multiplier.
//   LIMB       : limb width of the shared 16x16 multiplier
//   state_t    : controller states
//   limbs_of   : number of 16-bit limbs in a w-bit word
//   idx_width  : counter width able to index n items (at least 1 bit)
package dsp_seq_nmul_pkg;

    localparam int LIMB = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABS,
        ST_MUL,
        ST_SIGN,
        ST_DONE
    } state_t;

    function automatic int limbs_of(input int w);
        return w / LIMB;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dsp_seq_nmul_if.sv
// Operand/result handshake bundle for dsp_seq_nmul.
//   in_valid/in_ready/in_data    : operand set, operand k at in_data[k*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data : signed product, NOPS*WIDTH bits
//   master = producer/consumer side, slave = multiplier side
interface dsp_seq_nmul_if #(
    parameter int WIDTH = 16,
    parameter int NOPS  = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NOPS*WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [NOPS*WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dsp_seq_nmul_16mul.sv
// Combinational unsigned 16x16 -> 32 multiplier (the single shared DSP slice).
//   a, b : unsigned limbs
//   p    : full 32-bit product
module dsp_seq_nmul_16mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/dsp_seq_nmul.sv
// Sequential signed product of NOPS operands of WIDTH bits using one 16x16
// multiplier over 16-bit limbs in sign-magnitude form.
//   clk, rst : clock, asynchronous active-high reset
//   io       : operand/result handshake (slave side)
//   busy     : high in every state except IDLE
//
// state   | meaning
// IDLE    | waiting for an operand set, in_ready high
// ABS     | operands replaced by magnitudes, result sign and zero detect
// MUL     | one limb product per cycle accumulated into nsum_q
// SIGN    | apply result sign to the magnitude product
// DONE    | result presented until out_ready
module dsp_seq_nmul
    import dsp_seq_nmul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NOPS  = 3
) (
    input  logic               clk,
    input  logic               rst,
    dsp_seq_nmul_if.slave      io,
    output logic               busy
);
    localparam int L  = limbs_of(WIDTH);
    localparam int OW = NOPS * WIDTH;
    localparam int NL = OW / LIMB;
    localparam int IW = idx_width(NL);
    localparam int JW = idx_width(L);
    localparam int KW = idx_width(NOPS);
    localparam int SW = $clog2(OW) + 1;

    state_t            state;
    logic [WIDTH-1:0]  op_q [NOPS];
    logic [OW-1:0]     acc;
    logic [OW-1:0]     nsum_q;
    logic              sign_out;
    logic [IW-1:0]     i_cnt;
    logic [JW-1:0]     j_cnt;
    logic [KW-1:0]     k_cnt;

    logic [WIDTH-1:0]  mag [NOPS];
    logic              neg_all;
    logic              any_zero;
    logic [15:0]       acc_limb;
    logic [15:0]       op_limb;
    logic [31:0]       prod;
    logic [SW-1:0]     sh_amt;
    logic [OW-1:0]     nsum;
    logic              i_last;
    logic              j_last;
    logic              step_last;

    // Magnitude of -2^(WIDTH-1) wraps to itself, which is correct when read unsigned.
    always_comb begin
        neg_all  = 1'b0;
        any_zero = 1'b0;
        for (int n = 0; n < NOPS; n++) begin
            mag[n]   = op_q[n][WIDTH-1] ? -op_q[n] : op_q[n];
            neg_all  = neg_all ^ op_q[n][WIDTH-1];
            any_zero = any_zero | (op_q[n] == '0);
        end
    end

    always_comb begin
        acc_limb  = acc[LIMB*int'(i_cnt) +: LIMB];
        op_limb   = op_q[k_cnt][LIMB*int'(j_cnt) +: LIMB];
        sh_amt    = SW'(LIMB * (int'(i_cnt) + int'(j_cnt)));
        // Products landing above OW are provably zero, so truncation is exact.
        nsum      = nsum_q + (OW'(prod) << sh_amt);
        // During step k the accumulator holds k operands, i.e. k*L limbs.
        i_last    = (i_cnt == IW'(int'(k_cnt) * L - 1));
        j_last    = (j_cnt == JW'(L - 1));
        step_last = (k_cnt == KW'(NOPS - 1));
    end

    dsp_seq_nmul_16mul u_mul (
        .a (acc_limb),
        .b (op_limb),
        .p (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            busy         <= 1'b0;
            acc          <= '0;
            nsum_q       <= '0;
            sign_out     <= 1'b0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            k_cnt        <= '0;
            for (int n = 0; n < NOPS; n++) op_q[n] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        for (int n = 0; n < NOPS; n++) op_q[n] <= io.in_data[n*WIDTH +: WIDTH];
                        io.in_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    for (int n = 0; n < NOPS; n++) op_q[n] <= mag[n];
                    sign_out <= neg_all;
                    i_cnt    <= '0;
                    j_cnt    <= '0;
                    k_cnt    <= KW'(1);
                    nsum_q   <= '0;
                    if (any_zero) begin
                        acc   <= '0;
                        state <= ST_SIGN;
                    end else begin
                        acc   <= OW'(mag[0]);
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (i_last && j_last) begin
                        acc    <= nsum;
                        nsum_q <= '0;
                        i_cnt  <= '0;
                        j_cnt  <= '0;
                        if (step_last) state <= ST_SIGN;
                        else           k_cnt <= k_cnt + KW'(1);
                    end else begin
                        nsum_q <= nsum;
                        if (i_last) begin
                            i_cnt <= '0;
                            j_cnt <= j_cnt + JW'(1);
                        end else begin
                            i_cnt <= i_cnt + IW'(1);
                        end
                    end
                end
                ST_SIGN: begin
                    io.out_data  <= sign_out ? -acc : acc;
                    io.out_valid <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        io.in_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_seq_nmul.sv
module tb_dsp_seq_nmul;
    logic clk;
    logic rst;
    logic busy16;
    logic busy32;

    int n_assert;
    int n_fail;

    logic [47:0]  q16 [$];
    logic [127:0] q32 [$];

    dsp_seq_nmul_if #(.WIDTH(16), .NOPS(3)) bus16 ();
    dsp_seq_nmul_if #(.WIDTH(32), .NOPS(4)) bus32 ();

    dsp_seq_nmul #(.WIDTH(16), .NOPS(3)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .io   (bus16.slave),
        .busy (busy16)
    );

    dsp_seq_nmul #(.WIDTH(32), .NOPS(4)) u_dut32 (
        .clk  (clk),
        .rst  (rst),
        .io   (bus32.slave),
        .busy (busy32)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] model16(input logic [47:0] d);
        logic signed [47:0] p;
        logic signed [47:0] t;
        p = 48'sd1;
        for (int n = 0; n < 3; n++) begin
            t = $signed(d[n*16 +: 16]);
            p = p * t;
        end
        return p;
    endfunction

    function automatic logic [127:0] model32(input logic [127:0] d);
        logic signed [127:0] p;
        logic signed [127:0] t;
        p = 128'sd1;
        for (int n = 0; n < 4; n++) begin
            t = $signed(d[n*32 +: 32]);
            p = p * t;
        end
        return p;
    endfunction

    function automatic int lat16(input logic [47:0] d);
        for (int n = 0; n < 3; n++) if (d[n*16 +: 16] == 16'h0) return 2;
        return 5;
    endfunction

    function automatic int lat32(input logic [127:0] d);
        for (int n = 0; n < 4; n++) if (d[n*32 +: 32] == 32'h0) return 2;
        return 26;
    endfunction

    // Drives one operand set, waits for the result and checks latency and value.
    task automatic run16(input string tag, input logic [47:0] d);
        int lat;
        q16.push_back(model16(d));
        @(negedge clk);
        bus16.in_data  = d;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (!bus16.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(lat16(d)));
        check(tag, 128'(bus16.out_data), 128'(q16.pop_front()));
        if (bus16.out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_idle"}, 128'(bus16.in_ready), 128'(1'b1));
        end
    endtask

    task automatic run32(input string tag, input logic [127:0] d);
        int lat;
        q32.push_back(model32(d));
        @(negedge clk);
        bus32.in_data  = d;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        while (!bus32.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(lat32(d)));
        check(tag, bus32.out_data, q32.pop_front());
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_op16();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'h8000;
        if (r == 2) return 16'hFFFF;
        return 16'($urandom);
    endfunction

    function automatic logic [31:0] rnd_op32();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000_0000;
        if (r == 1) return 32'hFFFF_FFFF;
        if (r == 2) return 32'h7FFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        logic [47:0]  d16;
        logic [127:0] d32;
        logic [47:0]  exp16;

        n_assert = 0;
        n_fail   = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = '0;
        bus16.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_data   = '0;
        bus32.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready16",  128'(bus16.in_ready),  128'(1'b1));
        check("rst_out_valid16", 128'(bus16.out_valid), 128'(1'b0));
        check("rst_busy16",      128'(busy16),          128'(1'b0));
        check("rst_out16",       128'(bus16.out_data),  128'(0));
        check("rst_in_ready32",  128'(bus32.in_ready),  128'(1'b1));
        check("rst_busy32",      128'(busy32),          128'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        run16("p_5_m4_3", {16'd5, 16'hFFFC, 16'd3});
        check("p_5_m4_3_abs", 128'(bus16.out_data), 128'(48'hFFFF_FFFF_FFC4));
        run16("all_8000", {16'h8000, 16'h8000, 16'h8000});
        check("all_8000_abs", 128'(bus16.out_data), 128'(48'hE000_0000_0000));
        run16("m1_8000_8000", {16'h8000, 16'h8000, 16'hFFFF});
        check("m1_8000_8000_abs", 128'(bus16.out_data), 128'(48'hFFFF_C000_0000));
        run16("op1_zero", {16'd9, 16'h0000, 16'hFFF0});
        check("op1_zero_abs", 128'(bus16.out_data), 128'(0));
        run16("all_7fff", {16'h7FFF, 16'h7FFF, 16'h7FFF});
        run16("neg_neg_pos", {16'd1234, 16'hFF00, 16'h8001});

        for (int n = 0; n < 20; n++) begin
            d16 = {rnd_op16(), rnd_op16(), rnd_op16()};
            run16($sformatf("rnd16_%0d", n), d16);
        end

        // Backpressure: result must hold, new operands must be ignored.
        bus16.out_ready = 1'b0;
        d16   = {16'hFFFD, 16'd77, 16'h0101};
        exp16 = model16(d16);
        run16("bp", d16);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.in_data  = {16'd1, 16'd2, 16'd3};
            @(posedge clk);
            #1;
            check($sformatf("bp_out_%0d", c),   128'(bus16.out_data),  128'(exp16));
            check($sformatf("bp_valid_%0d", c), 128'(bus16.out_valid), 128'(1'b1));
            check($sformatf("bp_ready_%0d", c), 128'(bus16.in_ready),  128'(1'b0));
        end
        @(negedge clk);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_valid", 128'(bus16.out_valid), 128'(1'b0));
        check("bp_rel_ready", 128'(bus16.in_ready),  128'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_queue", 128'(busy16), 128'(1'b0));

        // Reset during MUL abandons the operation.
        @(negedge clk);
        bus16.in_data  = {16'd11, 16'd13, 16'd17};
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_busy", 128'(busy16), 128'(1'b1));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  128'(bus16.in_ready),  128'(1'b1));
        check("mid_rst_out_valid", 128'(bus16.out_valid), 128'(1'b0));
        check("mid_rst_busy",      128'(busy16),          128'(1'b0));
        check("mid_rst_out",       128'(bus16.out_data),  128'(0));
        @(negedge clk);
        rst = 1'b0;
        run16("after_rst", {16'hFFF9, 16'd6, 16'd5});

        // Wide configuration against the behavioural model.
        run32("w32_all_8000", {4{32'h8000_0000}});
        check("w32_all_8000_abs", bus32.out_data, {4'h1, 124'h0});
        run32("w32_zero", {32'd5, 32'h0, 32'hFFFF_FFFF, 32'd3});
        for (int n = 0; n < 30; n++) begin
            d32 = {rnd_op32(), rnd_op32(), rnd_op32(), rnd_op32()};
            run32($sformatf("rnd32_%0d", n), d32);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
